// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RISC sequencing controller.
// CTRL_ILLEGAL_TRAP_EN adds the TRAP state for illegal instructions.
package ctrl_pkg;

  localparam int unsigned OPC_W  = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned NSEL_W = 2;
  localparam int unsigned VSEL_W = 2;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_COMPUTE   = 3'd5,
    ST_WRITE_REG = 3'd6
`ifdef CTRL_ILLEGAL_TRAP_EN
    , ST_TRAP    = 3'd7
`endif
  } state_e;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
  localparam logic [OP_W-1:0] OP_AND     = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN     = 2'b11;
  localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
  localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;

  localparam logic [NSEL_W-1:0] NSEL_RN = 2'b00;
  localparam logic [NSEL_W-1:0] NSEL_RD = 2'b01;
  localparam logic [NSEL_W-1:0] NSEL_RM = 2'b10;

  localparam logic [VSEL_W-1:0] VSEL_C    = 2'b00;
  localparam logic [VSEL_W-1:0] VSEL_IMM8 = 2'b01;

  typedef struct packed {
    logic              w;
    logic [NSEL_W-1:0] nsel;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic [VSEL_W-1:0] vsel;
    logic              write;
    logic              err;
  } strobes_t;

  // First state after DECODE; ST_WAIT (or ST_TRAP) marks an illegal instruction.
  function automatic state_e first_step(input logic [OPC_W-1:0] opc,
                                        input logic [OP_W-1:0]  op);
    state_e nxt;
`ifdef CTRL_ILLEGAL_TRAP_EN
    nxt = ST_TRAP;
`else
    nxt = ST_WAIT;
`endif
    if (opc == OPC_MOV) begin
      if (op == OP_MOV_IMM)      nxt = ST_WRITE_IMM;
      else if (op == OP_MOV_REG) nxt = ST_GET_B;
    end else if (opc == OPC_ALU) begin
      if (op == OP_MVN) nxt = ST_GET_B;
      else              nxt = ST_GET_A;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_outputs.sv
// Combinational map from controller state and captured opcode/op to datapath strobes.
// CTRL_ILLEGAL_TRAP_EN enables the TRAP decode (err=1).
module ctrl_outputs
  import ctrl_pkg::*;
(
  input  state_e             state_i,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic [OP_W-1:0]    op_i,
  output strobes_t           strobes_o
);

  logic is_cmp;
  logic a_zero;

  assign is_cmp = (opcode_i == OPC_ALU) && (op_i == OP_CMP);
  // MOV-reg and MVN pass Rm through the ALU with A forced to zero.
  assign a_zero = ((opcode_i == OPC_MOV) && (op_i == OP_MOV_REG)) ||
                  ((opcode_i == OPC_ALU) && (op_i == OP_MVN));

  always_comb begin
    strobes_o      = '0;
    strobes_o.nsel = NSEL_RN;
    strobes_o.vsel = VSEL_C;
    case (state_i)
      ST_WAIT:      strobes_o.w = 1'b1;
      ST_DECODE:    ;
      ST_WRITE_IMM: begin
        strobes_o.nsel  = NSEL_RN;
        strobes_o.vsel  = VSEL_IMM8;
        strobes_o.write = 1'b1;
      end
      ST_GET_A: begin
        strobes_o.nsel  = NSEL_RN;
        strobes_o.loada = 1'b1;
      end
      ST_GET_B: begin
        strobes_o.nsel  = NSEL_RM;
        strobes_o.loadb = 1'b1;
      end
      ST_COMPUTE: begin
        strobes_o.loadc = !is_cmp;
        strobes_o.loads = is_cmp;
        strobes_o.asel  = a_zero;
      end
      ST_WRITE_REG: begin
        strobes_o.nsel  = NSEL_RD;
        strobes_o.vsel  = VSEL_C;
        strobes_o.write = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:      strobes_o.err = 1'b1;
`endif
      default:      ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Sequencing controller: state and opcode capture registers, strobes registered from next state.
// CTRL_ILLEGAL_TRAP_EN selects trap-until-reset handling of illegal instructions.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [OP_W-1:0]   op,
  output logic              w,
  output logic [NSEL_W-1:0] nsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [VSEL_W-1:0] vsel,
  output logic              write,
  output logic              err
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [OP_W-1:0]  op_q, op_d;
  strobes_t         out_q, out_d;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    op_d    = op_q;
    case (state_q)
      ST_WAIT: begin
        if (s) begin
          state_d = ST_DECODE;
          opc_d   = opcode;
          op_d    = op;
        end
      end
      ST_DECODE:    state_d = first_step(opc_q, op_q);
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_COMPUTE;
      ST_COMPUTE:   state_d = ((opc_q == OPC_ALU) && (op_q == OP_CMP)) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_d = ST_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:      state_d = ST_TRAP;
`endif
      default:      state_d = ST_WAIT;
    endcase
  end

  // Decoding the next state lets the strobes come straight from flops yet stay Moore-timed.
  ctrl_outputs u_outputs (
    .state_i   (state_d),
    .opcode_i  (opc_d),
    .op_i      (op_d),
    .strobes_o (out_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_WAIT;
      opc_q      <= '0;
      op_q       <= '0;
      out_q      <= '0;
      out_q.w    <= 1'b1;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  assign w     = out_q.w;
  assign nsel  = out_q.nsel;
  assign loada = out_q.loada;
  assign loadb = out_q.loadb;
  assign loadc = out_q.loadc;
  assign loads = out_q.loads;
  assign asel  = out_q.asel;
  assign bsel  = out_q.bsel;
  assign vsel  = out_q.vsel;
  assign write = out_q.write;
  assign err   = out_q.err;

endmodule
